// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: funct3 size codes, FSM encoding and lane helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // size is funct3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between the MEM-stage access unit and the memory.
interface mem_access_unit_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select plus sign/zero extension of a captured memory word.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(word >> {lane, 3'b000});
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_BU:   result = {24'h0, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_HU:   result = {16'h0, half_v};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack FSM, pipeline stall, store lanes, load extend.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                memread_mem,
  input  logic                memwrite_mem,
  input  logic [2:0]          funct3_mem,
  input  logic [31:0]         alu_result_mem,
  input  logic [31:0]         write_data_memory_mem,
  output logic [31:0]         data_from_memory_mem,
  output logic                mem_stall,
  output logic                access_err,
  mem_access_unit_if.master   dmem
);

  localparam logic [8:0] TimeoutW = 9'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] data_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;

  logic        access, legal_f3, misaligned, legal, illegal, timeout_hit;
  logic [31:0] ext_data;

  always_comb begin
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    case (funct3_mem)
      F3_B, F3_BU: legal_f3 = 1'b1;
      F3_H, F3_HU: begin
        legal_f3   = 1'b1;
        misaligned = alu_result_mem[0];
      end
      F3_W: begin
        legal_f3   = 1'b1;
        misaligned = |alu_result_mem[1:0];
      end
      default: ;
    endcase
  end

  assign access  = memread_mem | memwrite_mem;
  assign legal   = access & legal_f3 & ~misaligned;
  assign illegal = access & ~legal;

  // Abort on the TIMEOUT-th consecutive BUSY cycle that has no ack.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) == TimeoutW;

  assign mem_stall = ((state_q == StIdle) & legal) | (state_q == StBusy);

  mem_access_unit_load_extend u_load_extend (
    .word   (data_q),
    .lane   (lane_q),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  // An illegal access is never stalled, so the zero result must be visible in the same cycle.
  assign data_from_memory_mem = ((state_q == StIdle) && illegal) ? 32'h0 : ext_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StIdle;
      cnt_q           <= 8'h0;
      data_q          <= 32'h0;
      lane_q          <= 2'b00;
      funct3_q        <= F3_W;
      access_err      <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_be    <= 4'h0;
      dmem.dmem_wdata <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (legal) begin
            state_q         <= StBusy;
            cnt_q           <= 8'h0;
            lane_q          <= alu_result_mem[1:0];
            funct3_q        <= funct3_mem;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= memwrite_mem & ~memread_mem;
            dmem.dmem_addr  <= {alu_result_mem[31:2], 2'b00};
            dmem.dmem_be    <= byte_enable(funct3_mem[1:0], alu_result_mem[1:0]);
            dmem.dmem_wdata <= replicate(funct3_mem[1:0], write_data_memory_mem);
          end else if (illegal) begin
            access_err <= 1'b1;
            data_q     <= 32'h0;
          end
        end
        StBusy: begin
          if (dmem.dmem_ack) begin
            state_q       <= StDone;
            dmem.dmem_req <= 1'b0;
            data_q        <= dmem.dmem_we ? 32'h0 : dmem.dmem_rdata;
          end else if (timeout_hit) begin
            state_q       <= StDone;
            dmem.dmem_req <= 1'b0;
            access_err    <= 1'b1;
            data_q        <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a small ack-driving memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        rstn;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_memory_mem;
  logic [31:0] data_from_memory_mem;
  logic        mem_stall;
  logic        access_err;

  int tests = 0;
  int fails = 0;

  mem_access_unit_if dif ();

  mem_access_unit #(
    .TIMEOUT (4)
  ) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .memread_mem           (memread_mem),
    .memwrite_mem          (memwrite_mem),
    .funct3_mem            (funct3_mem),
    .alu_result_mem        (alu_result_mem),
    .write_data_memory_mem (write_data_memory_mem),
    .data_from_memory_mem  (data_from_memory_mem),
    .mem_stall             (mem_stall),
    .access_err            (access_err),
    .dmem                  (dif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_after;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
    int          stalls;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the DONE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int ack_after,
                           output int stalls, output int reqs, output logic [31:0] res,
                           output logic [31:0] s_addr, output logic [3:0] s_be,
                           output logic s_we, output logic [31:0] s_wdata);
    logic done;
    memread_mem           = rd;
    memwrite_mem          = wr;
    funct3_mem            = f3;
    alu_result_mem        = addr;
    write_data_memory_mem = wd;
    dif.dmem_rdata        = rdata;
    stalls  = 0;
    reqs    = 0;
    res     = 32'h0;
    s_addr  = 32'h0;
    s_be    = 4'h0;
    s_we    = 1'b0;
    s_wdata = 32'h0;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (!mem_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (dif.dmem_req) begin
          if (reqs == 0) begin
            s_addr  = dif.dmem_addr;
            s_be    = dif.dmem_be;
            s_we    = dif.dmem_we;
            s_wdata = dif.dmem_wdata;
          end
          if (reqs == ack_after) dif.dmem_ack = 1'b1;
          reqs++;
        end
        @(posedge clk);
        @(negedge clk);
        dif.dmem_ack = 1'b0;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL access_bound: stall still high after %0d cycles, required to end", stalls);
    end
    res          = data_from_memory_mem;
    memread_mem  = 1'b0;
    memwrite_mem = 1'b0;
    @(negedge clk);
  endtask

  int          stalls, reqs;
  logic [31:0] res, s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                 4'hF, 32'h0, 32'hDEADBEEF, 2};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0,
                 4'h8, 32'h0, 32'hFFFFFF80, 2};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0,
                 4'h8, 32'h0, 32'h00000080, 2};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 0,
                 4'hC, 32'hABCDABCD, 32'h0, 2};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0,
                 4'hC, 32'h0, 32'hFFFF80FF, 2};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0,
                 4'h3, 32'h0, 32'h00001234, 2};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 0,
                 4'h2, 32'hA5A5A5A5, 32'h0, 2};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0, 0,
                 4'hF, 32'hCAFEF00D, 32'h0, 2};
    vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 0,
                 4'h2, 32'h0, 32'h00000012, 2};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h108, 32'h11111111, 32'h01234567, 0,
                 4'hF, 32'h0, 32'h01234567, 2};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h76543210, 2,
                 4'hF, 32'h0, 32'h76543210, 4};
    vecs[11] = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h80FF1234, 1,
                 4'h4, 32'h0, 32'h000000FF, 3};

    rstn                  = 1'b0;
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b0;
    funct3_mem            = 3'b010;
    alu_result_mem        = 32'h0;
    write_data_memory_mem = 32'h0;
    dif.dmem_rdata        = 32'h0;
    dif.dmem_ack          = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'h0, dif.dmem_req}, 32'h0);
    check("rst_we", {31'h0, dif.dmem_we}, 32'h0);
    check("rst_addr", dif.dmem_addr, 32'h0);
    check("rst_be", {28'h0, dif.dmem_be}, 32'h0);
    check("rst_wdata", dif.dmem_wdata, 32'h0);
    check("rst_stall", {31'h0, mem_stall}, 32'h0);
    check("rst_err", {31'h0, access_err}, 32'h0);
    check("rst_data", data_from_memory_mem, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                vecs[i].rdata, vecs[i].ack_after, stalls, reqs, res,
                s_addr, s_be, s_we, s_wdata);
      check($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].stalls));
      check($sformatf("v%0d_addr", i), s_addr, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("v%0d_be", i), {28'h0, s_be}, {28'h0, vecs[i].be});
      check($sformatf("v%0d_we", i), {31'h0, s_we}, {31'h0, vecs[i].wr & ~vecs[i].rd});
      if (vecs[i].wr && !vecs[i].rd)
        check($sformatf("v%0d_wdata", i), s_wdata, vecs[i].wdata);
      else
        check($sformatf("v%0d_data", i), res, vecs[i].data);
      check($sformatf("v%0d_err", i), {31'h0, access_err}, 32'h0);
    end

    // Ack in the same cycle the timeout would fire: completion wins.
    do_access(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 32'h55AA33CC, 3,
              stalls, reqs, res, s_addr, s_be, s_we, s_wdata);
    check("ack4_reqs", 32'(reqs), 32'd4);
    check("ack4_stalls", 32'(stalls), 32'd5);
    check("ack4_data", res, 32'h55AA33CC);
    check("ack4_err", {31'h0, access_err}, 32'h0);

    // Reset in the middle of BUSY.
    memread_mem    = 1'b1;
    funct3_mem     = 3'b010;
    alu_result_mem = 32'h120;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rbusy_req_before", {31'h0, dif.dmem_req}, 32'h1);
    memread_mem = 1'b0;
    rstn        = 1'b0;
    #1;
    check("rbusy_req_async", {31'h0, dif.dmem_req}, 32'h0);
    check("rbusy_be_async", {28'h0, dif.dmem_be}, 32'h0);
    check("rbusy_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("rbusy_idle_req", {31'h0, dif.dmem_req}, 32'h0);
    @(negedge clk);
    do_access(1'b1, 1'b0, 3'b010, 32'h124, 32'h0, 32'h0BADF00D, 0,
              stalls, reqs, res, s_addr, s_be, s_we, s_wdata);
    check("rbusy_after_stalls", 32'(stalls), 32'd2);
    check("rbusy_after_data", res, 32'h0BADF00D);
    check("rbusy_after_addr", s_addr, 32'h124);

    // Timeout with no ack at all.
    do_access(1'b1, 1'b0, 3'b010, 32'h130, 32'h0, 32'hDEADBEEF, -1,
              stalls, reqs, res, s_addr, s_be, s_we, s_wdata);
    check("to_reqs", 32'(reqs), 32'd4);
    check("to_stalls", 32'(stalls), 32'd5);
    check("to_data", res, 32'h0);
    check("to_err", {31'h0, access_err}, 32'h1);
    #1;
    check("to_req_after", {31'h0, dif.dmem_req}, 32'h0);

    rstn = 1'b0;
    #1;
    check("rst2_err", {31'h0, access_err}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Misaligned lw: no request, no stall, error at the next edge and held.
    memread_mem    = 1'b1;
    funct3_mem     = 3'b010;
    alu_result_mem = 32'h101;
    #1;
    check("mis_stall", {31'h0, mem_stall}, 32'h0);
    check("mis_data", data_from_memory_mem, 32'h0);
    check("mis_err_before", {31'h0, access_err}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    memread_mem = 1'b0;
    #1;
    check("mis_err", {31'h0, access_err}, 32'h1);
    check("mis_req", {31'h0, dif.dmem_req}, 32'h0);

    // Stray ack while idle is ignored; illegal funct3 never requests.
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 32'hFFFFFFFF;
    memread_mem    = 1'b1;
    funct3_mem     = 3'b011;
    alu_result_mem = 32'h100;
    #1;
    check("f3_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    dif.dmem_ack = 1'b0;
    memread_mem  = 1'b0;
    #1;
    check("f3_req", {31'h0, dif.dmem_req}, 32'h0);
    check("stray_data", data_from_memory_mem, 32'h0);
    check("err_held", {31'h0, access_err}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the MEM stage of the 5-stage RV32I pipeline. It consumes the EX/MEM register outputs and runs a req/ack handshake to an external data memory. It freezes the pipeline with `mem_stall` until the access completes, then presents the aligned, sign- or zero-extended load result on `data_from_memory_mem` for the MEM/WB register. It also generates store byte enables and lane replication, and flags misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT`, 255: maximum BUSY cycles without `dmem_ack` before the access is aborted; legal range 1..255.
- `clk`  in  1  pipeline clock, rising edge.
- `rstn`  in  1  reset; one clock; asynchronous, active-low.
- `memread_mem`  in  1  load in MEM stage.
- `memwrite_mem`  in  1  store in MEM stage.
- `funct3_mem`  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; same encoding for sb/sh/sw.
- `alu_result_mem`  in  32  effective byte address.
- `write_data_memory_mem`  in  32  store data, rs2 value.
- `data_from_memory_mem`  out  32  extended load result, to MEM/WB.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM and bubble MEM/WB.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{alu_result_mem[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read word, valid with `dmem_ack`.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `access_err`  out  1  sticky error flag, cleared only by reset.

## Operation
- **Access decode**
  - access = `memread_mem | memwrite_mem`.
  - If both are set, treat it as a load; the write is suppressed.
- **Illegal access:** funct3 ∈ {011,110,111}, lw with addr[1:0]≠0, or halfword with addr[0]=1.
  - No request is issued.
  - Set `access_err`; `data_from_memory_mem`=0.
  - No stall.
- **Byte enables**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
  - Loads drive the same be with `dmem_we`=0.
- **Store data:** sb → `{4{wd[7:0]}}`; sh → `{2{wd[15:0]}}`; sw → wd.
- **Load extraction:** select lane by captured addr[1:0]; sign-extend for lb/lh, zero-extend for lbu/lhu.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE: on a legal access, latch addr/be/wdata/we/funct3 and go to BUSY. Otherwise stay.
  - BUSY: `dmem_req`=1 with stable outputs.
    - On `dmem_ack`: capture `dmem_rdata` and go to DONE.
    - When the wait counter reaches `TIMEOUT`: set `access_err`, load data=0, go to DONE.
  - DONE: present the result, then unconditionally go to IDLE.
- **Wait counter:** 8 bits; cleared on IDLE→BUSY; increments each BUSY cycle without ack.
- **Stall:** `mem_stall` = (IDLE & legal access) | BUSY. It is combinational; DONE has `mem_stall`=0 so the pipeline advances exactly once.
- `dmem_ack` outside BUSY is ignored.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered.

## Timing
- **Reset:** asynchronous, active-low.
  - State IDLE; `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0.
  - Data register 0, counter 0, `access_err`=0.
  - `mem_stall` = 0 as long as no access is presented.
- **Latency:** access seen in cycle t → `dmem_req` high from t+1.
  - Ack in cycle t+k (k≥1) → DONE in t+k+1 → MEM/WB captures at the end of t+k+1.
  - Minimum 2 stall cycles.
- **Request hold:** `dmem_req` stays high continuously until the ack cycle or the timeout cycle. It drops in the cycle after; no back-to-back requests without an intervening DONE/IDLE.
- **Timeout:** abort occurs in the cycle the counter equals `TIMEOUT` with no ack. Ack arriving in that same cycle wins; no error is set.
- **Reset mid-BUSY:** `dmem_req` drops asynchronously. The memory must tolerate an abandoned request.
- **Illegal access:** `access_err` is set at the next edge; the pipeline is not stalled.

## Structure
- Shared pipeline package:
  - funct3 size codes `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - FSM state encoding.
  - `TIMEOUT` default.
- One sub-module, `load_extend`: combinational lane select plus sign/zero extension, (word, addr[1:0], funct3) → 32-bit.
- The top level holds the FSM, the counter and the output registers.

## Test plan
- **lw:** lw addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF → `dmem_be`=1111, `dmem_addr`=0x100, exactly 2 stall cycles, `data_from_memory_mem`=0xDEADBEEF in DONE.
- **lb / lbu:** lb addr 0x103, rdata 0x80FF1234 → be 1000, result 0xFFFFFF80. Repeat as lbu → 0x00000080.
- **sh:** sh addr 0x202, wd 0x0000ABCD → `dmem_we`=1, be 1100, `dmem_wdata`=0xABCDABCD, `dmem_addr`=0x200.
- **Misaligned lw:** lw addr 0x101 → no `dmem_req`, `mem_stall`=0, `access_err`=1 next cycle and held.
- **Timeout:** `TIMEOUT`=4, no ack → req high 4 cycles, then DONE with data 0 and `access_err`=1. Separately, ack on the 4th cycle → normal completion, no error.
- **Reset mid-BUSY:** rstn low mid-BUSY → `dmem_req`=0 immediately. After release, state is IDLE and a following lw completes normally.
